cali_err_gen: RTL and testbench
===============================

CALI_ERR_GEN -- requirements
Module: cali_err_gen

Interface
REQ-001 SHALL have parameter WIN_LOG2, default 10: log2 of the number of valid samples per correlation window during sync search.
REQ-002 SHALL have parameter SYNC_DLY_INIT, default 3'd0: SYNC_DLY value after reset.
REQ-003 SHALL have port CLK input 1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port NRST input 1: reset, asynchronous and active-low.
REQ-005 SHALL have port EN input 1: block enable.
REQ-006 SHALL have port FCW_FRAC input 16: unsigned fractional frequency control word, Q0.16.
REQ-007 SHALL have port PD_SIGN input 1: bang-bang phase detector decision; 1 = late (positive error), 0 = early.
REQ-008 SHALL have port PD_VALID input 1: PD_SIGN is valid this cycle.
REQ-009 SHALL have port ERR_SHIFT input 4: error magnitude exponent, step = 2^ERR_SHIFT, legal range 0..14.
REQ-010 SHALL have port SYNC_START input 1: one-cycle pulse that starts the delay search.
REQ-011 SHALL have port X_OUT output 16: registered phase-accumulator fraction, Q0.16, feeding the calibrator X input.
REQ-012 SHALL have port CARRY output 1: accumulator overflow this cycle, i.e. the divider modulus +1 request.
REQ-013 SHALL have port ERR_OUT output 16: signed error sample feeding the calibrator ERR input.
REQ-014 SHALL have port ERR_VALID output 1: ERR_OUT is meaningful.
REQ-015 SHALL have port SYNC_DLY output 3: selected X-to-ERR alignment delay.
REQ-016 SHALL have port SYNC_BUSY output 1: search in progress.
REQ-017 SHALL have port SYNC_DONE output 1: one-cycle pulse at search completion.

Function
REQ-018 SHALL compute acc_next = acc + FCW_FRAC mod 2^16 each cycle with EN=1; X_OUT = acc; CARRY = 1 exactly in the cycle X_OUT takes a wrapped value.
REQ-019 SHALL hold acc, X_OUT and the history while EN=0, and drive CARRY=0.
REQ-020 SHALL keep an 8-entry history hist[k] = X_OUT value from k+1 enabled cycles earlier, k=0..7, shifting on every EN=1 cycle.
REQ-021 SHALL register ERR_OUT with 1-cycle latency: EN & PD_VALID gives +2^ERR_SHIFT if PD_SIGN=1 and -2^ERR_SHIFT if PD_SIGN=0; otherwise 0. ERR_VALID = registered EN & PD_VALID.
REQ-022 SHALL implement the search FSM with states IDLE, CLEAR, ACCUM, COMPARE and DONE; SYNC_BUSY = (state != IDLE).
REQ-023 SHALL transition IDLE->CLEAR on SYNC_START & EN, setting d=0, best=0 and best_d=0; SYNC_START SHALL be ignored outside IDLE.
REQ-024 SHALL, in CLEAR (1 cycle), zero corr and the sample counter, then go to ACCUM.
REQ-025 SHALL, in ACCUM, on each PD_VALID cycle add xc when PD_SIGN=1 and subtract xc when PD_SIGN=0, where xc = hist[d] - 32768 (17-bit signed); corr is signed 17+WIN_LOG2 bits with no saturation; after 2^WIN_LOG2 valid samples, go to COMPARE.
REQ-026 SHALL, in COMPARE (1 cycle), set best=|corr| and best_d=d if |corr| > best (strict); ties keep the lower d. If d=7 go to DONE, else d=d+1 and go to CLEAR.
REQ-027 SHALL, in DONE (1 cycle), load SYNC_DLY=best_d, pulse SYNC_DONE=1 and return to IDLE.
REQ-028 SHALL, on EN=0 in any non-IDLE state, abort to IDLE at the next edge, leave SYNC_DLY unchanged and not assert SYNC_DONE.
REQ-029 SHALL leave X_OUT, CARRY and ERR_OUT behaviour unaffected by the search.

Reset
REQ-030 SHALL, while NRST=0, force acc=0, X_OUT=0, hist=0, CARRY=0, ERR_OUT=0, ERR_VALID=0, SYNC_DLY=SYNC_DLY_INIT, SYNC_BUSY=0, SYNC_DONE=0, FSM=IDLE and corr=best=best_d=d=0.
REQ-031 SHALL, on reset assertion mid-search, abort immediately; on release, resume in IDLE.

Verification
REQ-032 Release reset with FCW_FRAC=0x4000 and EN=1 -> X_OUT = 0x4000, 0x8000, 0xC000, 0x0000, 0x4000; CARRY=1 only on the 0x0000 cycle.
REQ-033 ERR_SHIFT=4 with PD_VALID=1, PD_SIGN=1 -> ERR_OUT=+16 one cycle later; PD_SIGN=0 -> -16; PD_VALID=0 -> ERR_OUT=0 and ERR_VALID=0.
REQ-034 FCW_FRAC=0x1357, PD_VALID=1, PD_SIGN=(hist[3]>=0x8000) from a bench model, pulse SYNC_START -> SYNC_BUSY held for 8*(2^10+2)+1 cycles, then SYNC_DONE for one cycle with SYNC_DLY=3.
REQ-035 FCW_FRAC=0x4000, PD_SIGN=1 constant, search -> every |corr| is equal, so SYNC_DLY=0 via the tie rule.
REQ-036 Drop EN for one cycle during ACCUM with d=2 -> FSM in IDLE next cycle, SYNC_DLY keeps its previous value, no SYNC_DONE, X_OUT held that cycle.
REQ-037 Assert NRST mid-ACCUM -> all outputs take REQ-030 values immediately; a new SYNC_START after release runs a full search normally.

Source files
------------

// File: rtl/cali_err_gen.sv
// rtl/cali_err_gen.sv - fractional phase accumulator, BBPD error generator and X-to-ERR delay search
module cali_err_gen #(
  parameter int         WIN_LOG2      = 10,
  parameter logic [2:0] SYNC_DLY_INIT = 3'd0
) (
  input  logic        CLK,
  input  logic        NRST,
  input  logic        EN,
  input  logic [15:0] FCW_FRAC,
  input  logic        PD_SIGN,
  input  logic        PD_VALID,
  input  logic [3:0]  ERR_SHIFT,
  input  logic        SYNC_START,
  output logic [15:0] X_OUT,
  output logic        CARRY,
  output logic [15:0] ERR_OUT,
  output logic        ERR_VALID,
  output logic [2:0]  SYNC_DLY,
  output logic        SYNC_BUSY,
  output logic        SYNC_DONE
);

  localparam int CW = 17 + WIN_LOG2;

  typedef enum logic [2:0] {IDLE, CLEAR, ACCUM, COMPARE, DONE} state_t;

  state_t               state;
  logic [15:0]          hist [8];
  logic [2:0]           d;
  logic [2:0]           best_d;
  logic [CW-1:0]        best;
  logic signed [CW-1:0] corr;
  logic [WIN_LOG2-1:0]  cnt;

  logic [16:0]          acc_sum;
  logic [15:0]          err_mag;
  logic [15:0]          err_next;
  logic signed [16:0]   xc;
  logic signed [CW-1:0] xc_ext;
  logic [CW-1:0]        corr_abs;

  assign acc_sum  = {1'b0, X_OUT} + {1'b0, FCW_FRAC};
  assign err_mag  = 16'd1 << ERR_SHIFT;
  assign err_next = PD_SIGN ? err_mag : -err_mag;
  // Centre the delayed phase around zero so it correlates with the sign decision
  assign xc       = $signed({1'b0, hist[d]}) - 17'sd32768;
  assign xc_ext   = {{(CW-17){xc[16]}}, xc};
  assign corr_abs = corr[CW-1] ? -corr : corr;

  assign SYNC_BUSY = (state != IDLE);

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      X_OUT     <= '0;
      CARRY     <= 1'b0;
      ERR_OUT   <= '0;
      ERR_VALID <= 1'b0;
      for (int k = 0; k < 8; k++) hist[k] <= '0;
    end else begin
      ERR_OUT   <= (EN && PD_VALID) ? err_next : 16'd0;
      ERR_VALID <= EN && PD_VALID;
      if (EN) begin
        X_OUT   <= acc_sum[15:0];
        CARRY   <= acc_sum[16];
        hist[0] <= X_OUT;
        for (int k = 1; k < 8; k++) hist[k] <= hist[k-1];
      end else begin
        CARRY <= 1'b0;
      end
    end
  end

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      state     <= IDLE;
      d         <= '0;
      best      <= '0;
      best_d    <= '0;
      corr      <= '0;
      cnt       <= '0;
      SYNC_DLY  <= SYNC_DLY_INIT;
      SYNC_DONE <= 1'b0;
    end else begin
      SYNC_DONE <= 1'b0;
      if (state != IDLE && !EN) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (SYNC_START && EN) begin
              state  <= CLEAR;
              d      <= '0;
              best   <= '0;
              best_d <= '0;
            end
          end
          CLEAR: begin
            corr  <= '0;
            cnt   <= '0;
            state <= ACCUM;
          end
          ACCUM: begin
            if (PD_VALID) begin
              corr <= PD_SIGN ? corr + xc_ext : corr - xc_ext;
              cnt  <= cnt + 1'b1;
              if (&cnt) state <= COMPARE;
            end
          end
          COMPARE: begin
            // Strict compare: on equal magnitude the earlier (lower) delay wins
            if (corr_abs > best) begin
              best   <= corr_abs;
              best_d <= d;
            end
            if (d == 3'd7) begin
              state <= DONE;
            end else begin
              d     <= d + 3'd1;
              state <= CLEAR;
            end
          end
          DONE: begin
            SYNC_DLY  <= best_d;
            SYNC_DONE <= 1'b1;
            state     <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cali_err_gen.sv
// tb/tb_cali_err_gen.sv - self-checking bench for cali_err_gen
module tb_cali_err_gen;

  logic        CLK, NRST, EN, PD_SIGN, PD_VALID, SYNC_START;
  logic [15:0] FCW_FRAC;
  logic [3:0]  ERR_SHIFT;
  logic [15:0] X_OUT, ERR_OUT;
  logic        CARRY, ERR_VALID, SYNC_BUSY, SYNC_DONE;
  logic [2:0]  SYNC_DLY;

  cali_err_gen dut (
    .CLK(CLK), .NRST(NRST), .EN(EN), .FCW_FRAC(FCW_FRAC), .PD_SIGN(PD_SIGN),
    .PD_VALID(PD_VALID), .ERR_SHIFT(ERR_SHIFT), .SYNC_START(SYNC_START),
    .X_OUT(X_OUT), .CARRY(CARRY), .ERR_OUT(ERR_OUT), .ERR_VALID(ERR_VALID),
    .SYNC_DLY(SYNC_DLY), .SYNC_BUSY(SYNC_BUSY), .SYNC_DONE(SYNC_DONE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic             v;
    logic             s;
    logic [7:0][15:0] h;
  } ent_t;

  int          checks = 0;
  int          failures = 0;
  logic [15:0] m_x;
  logic        m_carry;
  logic [15:0] m_hist [8];
  logic [15:0] m_err;
  logic        m_ev;
  bit          logging = 0;
  ent_t        lg[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_x = '0; m_carry = 1'b0; m_err = '0; m_ev = 1'b0;
    for (int k = 0; k < 8; k++) m_hist[k] = '0;
  endtask

  // One clock: log the cycle's inputs, advance the reference model, compare the datapath.
  task automatic step();
    ent_t        e;
    logic        en_i, v_i, s_i;
    logic [3:0]  sh_i;
    logic [15:0] f_i;
    int          mag, tmp;
    en_i = EN; v_i = PD_VALID; s_i = PD_SIGN; sh_i = ERR_SHIFT; f_i = FCW_FRAC;
    if (logging) begin
      e.v = v_i; e.s = s_i;
      for (int k = 0; k < 8; k++) e.h[k] = m_hist[k];
      lg.push_back(e);
    end
    @(posedge CLK); #1;
    if (en_i) begin
      for (int k = 7; k > 0; k--) m_hist[k] = m_hist[k-1];
      m_hist[0] = m_x;
      {m_carry, m_x} = {1'b0, m_x} + {1'b0, f_i};
    end else begin
      m_carry = 1'b0;
    end
    mag  = 1 << sh_i;
    m_ev = en_i && v_i;
    tmp  = m_ev ? (s_i ? mag : -mag) : 0;
    m_err = tmp[15:0];
    check("x_out", X_OUT, m_x);
    check("carry", CARRY, m_carry);
    check("err_out", ERR_OUT, m_err);
    check("err_valid", ERR_VALID, m_ev);
  endtask

  task automatic drive_pd(input int mode);
    case (mode)
      0: begin PD_VALID = 1'b1; PD_SIGN = (m_hist[3] >= 16'h8000); end
      1: begin PD_VALID = 1'b1; PD_SIGN = 1'b1; end
      default: begin
        PD_VALID  = ($urandom_range(0, 3) != 0);
        PD_SIGN   = $urandom_range(0, 1);
        ERR_SHIFT = $urandom_range(0, 14);
      end
    endcase
  endtask

  // Replay the logged cycles: cycle 0 carries the start pulse, each window is
  // one clear cycle, 1024 valid samples, one compare cycle; DONE follows window 7.
  task automatic eval_search(output int exp_dly, output int exp_busy);
    int    i;
    int    cnt;
    longint best, corr, xc, a;
    i = 1; best = 0; exp_dly = 0;
    for (int dd = 0; dd < 8; dd++) begin
      i++;
      corr = 0; cnt = 0;
      while (cnt < 1024 && i < lg.size()) begin
        if (lg[i].v) begin
          xc = longint'(lg[i].h[dd]) - 32768;
          corr += lg[i].s ? xc : -xc;
          cnt++;
        end
        i++;
      end
      a = (corr < 0) ? -corr : corr;
      if (a > best) begin best = a; exp_dly = dd; end
      i++;
    end
    exp_busy = i;
  endtask

  task automatic run_search(input int mode, input string tag);
    int busy_n, cyc, exp_dly, exp_busy;
    bit fin;
    busy_n = 0; cyc = 0; fin = 0;
    lg.delete();
    logging = 1;
    SYNC_START = 1'b1;
    drive_pd(mode);
    step();
    SYNC_START = 1'b0;
    while (!fin && cyc < 40000) begin
      if (SYNC_BUSY) busy_n++;
      if (SYNC_DONE) begin
        fin = 1;
      end else begin
        drive_pd(mode);
        step();
        cyc++;
      end
    end
    logging = 0;
    check({tag, "_finished"}, fin, 1'b1);
    eval_search(exp_dly, exp_busy);
    check({tag, "_busy_cycles"}, busy_n, exp_busy);
    check({tag, "_dly"}, SYNC_DLY, exp_dly);
    check({tag, "_busy_at_done"}, SYNC_BUSY, 1'b0);
    drive_pd(mode);
    step();
    check({tag, "_done_one_cycle"}, SYNC_DONE, 1'b0);
  endtask

  initial begin
    logic [15:0] exp_x [5];
    logic        exp_c [5];
    bit          stray;
    exp_x = '{16'h4000, 16'h8000, 16'hC000, 16'h0000, 16'h4000};
    exp_c = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    NRST = 1'b0; EN = 1'b0; FCW_FRAC = 16'h4000; PD_SIGN = 1'b0; PD_VALID = 1'b0;
    ERR_SHIFT = 4'd4; SYNC_START = 1'b0;
    model_reset();
    #12;
    check("rst_x_out", X_OUT, 16'h0);
    check("rst_carry", CARRY, 1'b0);
    check("rst_err_out", ERR_OUT, 16'h0);
    check("rst_err_valid", ERR_VALID, 1'b0);
    check("rst_sync_dly", SYNC_DLY, 3'd0);
    check("rst_busy", SYNC_BUSY, 1'b0);
    check("rst_done", SYNC_DONE, 1'b0);

    @(negedge CLK); NRST = 1'b1; EN = 1'b1;
    for (int n = 0; n < 5; n++) begin
      step();
      check("acc_seq_x", X_OUT, exp_x[n]);
      check("acc_seq_carry", CARRY, exp_c[n]);
    end

    PD_VALID = 1'b1; PD_SIGN = 1'b1; step();
    check("err_plus16", ERR_OUT, 16'd16);
    PD_SIGN = 1'b0; step();
    check("err_minus16", ERR_OUT, 16'hFFF0);
    PD_VALID = 1'b0; step();
    check("err_none", ERR_OUT, 16'h0);
    check("err_none_valid", ERR_VALID, 1'b0);
    EN = 1'b0; PD_VALID = 1'b1; step(); step();
    check("en_low_carry", CARRY, 1'b0);
    check("en_low_err_valid", ERR_VALID, 1'b0);
    EN = 1'b1;
    ERR_SHIFT = 4'd14; PD_VALID = 1'b1; PD_SIGN = 1'b0; step();
    check("err_shift14", ERR_OUT, 16'hC000);
    ERR_SHIFT = 4'd4;

    FCW_FRAC = 16'h1357;
    run_search(0, "aligned");
    check("aligned_dly_is_3", SYNC_DLY, 3'd3);

    SYNC_START = 1'b1; drive_pd(0); step(); SYNC_START = 1'b0;
    for (int n = 0; n < 2500; n++) begin drive_pd(0); step(); end
    check("abort_busy_before", SYNC_BUSY, 1'b1);
    EN = 1'b0; step();
    check("abort_idle", SYNC_BUSY, 1'b0);
    check("abort_no_done", SYNC_DONE, 1'b0);
    check("abort_dly_kept", SYNC_DLY, 3'd3);
    EN = 1'b1;
    stray = 0;
    for (int n = 0; n < 20; n++) begin
      drive_pd(0); step();
      if (SYNC_BUSY || SYNC_DONE) stray = 1;
    end
    check("abort_stays_idle", stray, 1'b0);

    FCW_FRAC = 16'($urandom_range(1, 65535));
    run_search(2, "random");

    FCW_FRAC = 16'h1357; ERR_SHIFT = 4'd4;
    SYNC_START = 1'b1; drive_pd(0); step(); SYNC_START = 1'b0;
    for (int n = 0; n < 500; n++) begin drive_pd(0); step(); end
    NRST = 1'b0; #1;
    model_reset();
    check("mid_rst_x_out", X_OUT, 16'h0);
    check("mid_rst_carry", CARRY, 1'b0);
    check("mid_rst_err_out", ERR_OUT, 16'h0);
    check("mid_rst_err_valid", ERR_VALID, 1'b0);
    check("mid_rst_sync_dly", SYNC_DLY, 3'd0);
    check("mid_rst_busy", SYNC_BUSY, 1'b0);
    check("mid_rst_done", SYNC_DONE, 1'b0);
    @(negedge CLK); NRST = 1'b1;
    run_search(0, "after_reset");
    check("after_reset_dly_is_3", SYNC_DLY, 3'd3);

    FCW_FRAC = 16'h4000;
    run_search(1, "tie");
    check("tie_dly_is_0", SYNC_DLY, 3'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
